// File: rtl/multicycle_main_controller.sv
// Multi-cycle control FSM for the RV32I core: sequences each instruction through the
// shared-ALU / single-memory datapath, with a ready handshake, memory timeout and sticky trap.
module multicycle_main_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter bit ENABLE_U    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic [2:0] imm_src,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_UPPER    = 4'd12,
    S_IDLE     = 4'd14,
    S_TRAP     = 4'd15
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_TIMEOUT = 2'b10
  } cause_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // The counter must be able to hold MEM_TIMEOUT itself: a request may stall for
  // MEM_TIMEOUT cycles and still complete in the cycle the count sits at the limit.
  localparam bit               TIMEOUT_EN = (MEM_TIMEOUT > 0);
  localparam int               CNT_W      = TIMEOUT_EN ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  cause_t           cause_q, cause_d;
  logic             trap_q, trap_d;
  logic [CNT_W-1:0] cnt_q;

  logic is_load, is_store, is_rtype, is_itype, is_branch, is_jal, is_lui, is_auipc;
  logic is_upper, timeout;

  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_rtype  = (opcode == OP_RTYPE);
  assign is_itype  = (opcode == OP_ITYPE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_lui    = (opcode == OP_LUI);
  assign is_auipc  = (opcode == OP_AUIPC);
  assign is_upper  = ENABLE_U && (is_lui || is_auipc);

  assign timeout = TIMEOUT_EN && (cnt_q == CNT_LIMIT) && !mem_ready;

  // NOTE: state-holding logic uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      trap_q  <= 1'b0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      trap_q  <= trap_d;
      cause_q <= cause_d;
    end
  end

  // Counts consecutive unanswered cycles of the current request only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (TIMEOUT_EN && mem_req && !mem_ready && (state_d == state_q)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      cnt_q <= '0;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    trap_d     = trap_q;
    cause_d    = cause_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end

      // ALUOut <= OldPC + imm, the branch/JAL target, whatever the instruction turns out to be.
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        if (is_load || is_store) begin
          state_d = S_MEMADR;
        end else if (is_rtype) begin
          state_d = S_EXECR;
        end else if (is_itype) begin
          state_d = S_EXECI;
        end else if (is_branch) begin
          state_d = S_BRANCH;
        end else if (is_jal) begin
          state_d = S_JAL;
        end else if (is_upper) begin
          state_d = S_UPPER;
        end else begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_ILLEGAL;
        end
      end

      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = is_store ? S_MEMWRITE : S_MEMREAD;
      end

      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end

      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEMWRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end

      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end

      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end

      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end

      // PC takes the target from ALUOut while the live ALU forms the link value OldPC+4.
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end

      S_UPPER: begin
        alu_src_a = is_lui ? 2'b11 : 2'b01;
        alu_src_b = 2'b01;
        state_d   = S_ALUWB;
      end

      S_TRAP: state_d = S_TRAP;

      default: state_d = S_IDLE;
    endcase

    // mem_req is only raised in FETCH, MEMREAD and MEMWRITE, so this covers all three.
    if (mem_req && timeout) begin
      state_d = S_TRAP;
      trap_d  = 1'b1;
      cause_d = CAUSE_TIMEOUT;
    end
  end

  always_comb begin
    imm_src = 3'b000;
    if (is_store)                imm_src = 3'b001;
    else if (is_branch)          imm_src = 3'b010;
    else if (is_jal)             imm_src = 3'b011;
    else if (is_lui || is_auipc) imm_src = 3'b100;
  end

  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_multicycle_main_controller.sv
// Bench for multicycle_main_controller: two instances (timeout 4 with U-type, timeout off
// without U-type) share stimulus and are compared every cycle against a plan-based model.
module tb_multicycle_main_controller;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  localparam int TO_A = 4;
  localparam bit EU_A = 1'b1;
  localparam int TO_B = 0;
  localparam bit EU_B = 1'b0;

  typedef struct packed {
    logic [3:0] state;
    logic       trap;
    logic [1:0] cause;
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic       reg_write;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] alu_op;
    logic [1:0] res_src;
    logic [2:0] imm;
  } obs_t;

  typedef struct packed {
    int         st;
    logic       tr;
    logic [1:0] cs;
    int         stall;
    logic [6:0] op;
    int         idx;
  } model_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_ready;
  logic [6:0] opcode;
  bit         done = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         upper_seq [4] = '{0, 1, 12, 8};

  logic       a_mem_req, a_mem_we, a_adr_src, a_ir_write, a_pc_write, a_branch, a_reg_write, a_trap;
  logic [1:0] a_alu_src_a, a_alu_src_b, a_alu_op, a_result_src, a_trap_cause;
  logic [2:0] a_imm_src;
  logic [3:0] a_state_dbg;
  logic       b_mem_req, b_mem_we, b_adr_src, b_ir_write, b_pc_write, b_branch, b_reg_write, b_trap;
  logic [1:0] b_alu_src_a, b_alu_src_b, b_alu_op, b_result_src, b_trap_cause;
  logic [2:0] b_imm_src;
  logic [3:0] b_state_dbg;

  obs_t   obs_a, obs_b;
  model_t m [2];

  always #5 clk = ~clk;

  multicycle_main_controller #(.MEM_TIMEOUT(TO_A), .ENABLE_U(EU_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .adr_src(a_adr_src), .ir_write(a_ir_write),
    .pc_write(a_pc_write), .branch(a_branch), .reg_write(a_reg_write),
    .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b), .alu_op(a_alu_op),
    .result_src(a_result_src), .imm_src(a_imm_src), .trap(a_trap),
    .trap_cause(a_trap_cause), .state_dbg(a_state_dbg)
  );

  multicycle_main_controller #(.MEM_TIMEOUT(TO_B), .ENABLE_U(EU_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .adr_src(b_adr_src), .ir_write(b_ir_write),
    .pc_write(b_pc_write), .branch(b_branch), .reg_write(b_reg_write),
    .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .alu_op(b_alu_op),
    .result_src(b_result_src), .imm_src(b_imm_src), .trap(b_trap),
    .trap_cause(b_trap_cause), .state_dbg(b_state_dbg)
  );

  assign obs_a = {a_state_dbg, a_trap, a_trap_cause, a_mem_req, a_mem_we, a_adr_src, a_ir_write,
                  a_pc_write, a_branch, a_reg_write, a_alu_src_a, a_alu_src_b, a_alu_op,
                  a_result_src, a_imm_src};
  assign obs_b = {b_state_dbg, b_trap, b_trap_cause, b_mem_req, b_mem_we, b_adr_src, b_ir_write,
                  b_pc_write, b_branch, b_reg_write, b_alu_src_a, b_alu_src_b, b_alu_op,
                  b_result_src, b_imm_src};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [14:0] ctrl_bits(obs_t o);
    return {o.mem_req, o.mem_we, o.adr_src, o.ir_write, o.pc_write, o.branch, o.reg_write,
            o.src_a, o.src_b, o.alu_op, o.res_src};
  endfunction

  // States visited after DECODE for each instruction class, ending back in FETCH.
  function automatic int plan_at(logic [6:0] op, int idx);
    int p [4];
    case (op)
      OP_LOAD:  p = '{2, 3, 4, 0};
      OP_STORE: p = '{2, 5, 0, 0};
      OP_R:     p = '{6, 8, 0, 0};
      OP_I:     p = '{7, 8, 0, 0};
      OP_BR:    p = '{9, 0, 0, 0};
      OP_JAL:   p = '{10, 8, 0, 0};
      default:  p = '{12, 8, 0, 0};
    endcase
    return p[idx];
  endfunction

  function automatic logic [2:0] imm_for(logic [6:0] op);
    case (op)
      OP_STORE:         return 3'b001;
      OP_BR:            return 3'b010;
      OP_JAL:           return 3'b011;
      OP_LUI, OP_AUIPC: return 3'b100;
      default:          return 3'b000;
    endcase
  endfunction

  function automatic model_t reset_model();
    model_t n = '0;
    n.st = 14;
    return n;
  endfunction

  function automatic model_t next_model(model_t cur, int to, bit eu, logic [6:0] op, logic rdy);
    model_t n = cur;
    bit legal;
    case (cur.st)
      14: begin n.st = 0; n.stall = 0; end
      15: ;
      1: begin
        legal = (op == OP_LOAD) || (op == OP_STORE) || (op == OP_R) || (op == OP_I) ||
                (op == OP_BR) || (op == OP_JAL) || (eu && (op == OP_LUI || op == OP_AUIPC));
        if (legal) begin
          n.op  = op;
          n.st  = plan_at(op, 0);
          n.idx = 1;
        end else begin
          n.st = 15; n.tr = 1'b1; n.cs = 2'b01;
        end
      end
      0, 3, 5: begin
        if (rdy) begin
          n.stall = 0;
          if (cur.st == 0) n.st = 1;
          else begin
            n.st  = plan_at(cur.op, cur.idx);
            n.idx = cur.idx + 1;
          end
        end else if (to > 0 && cur.stall == to) begin
          n.st = 15; n.tr = 1'b1; n.cs = 2'b10; n.stall = 0;
        end else if (to > 0) begin
          n.stall = cur.stall + 1;
        end
      end
      default: begin
        n.st  = plan_at(cur.op, cur.idx);
        n.idx = cur.idx + 1;
      end
    endcase
    return n;
  endfunction

  function automatic obs_t expect_out(model_t s, logic [6:0] op, logic rdy);
    obs_t e = '0;
    e.state = 4'(s.st);
    e.trap  = s.tr;
    e.cause = s.cs;
    e.imm   = imm_for(op);
    case (s.st)
      0:  begin e.mem_req = 1'b1; e.src_b = 2'b10; e.res_src = 2'b10;
                e.ir_write = rdy; e.pc_write = rdy; end
      1:  begin e.src_a = 2'b01; e.src_b = 2'b01; end
      2:  begin e.src_a = 2'b10; e.src_b = 2'b01; end
      3:  begin e.mem_req = 1'b1; e.adr_src = 1'b1; end
      4:  begin e.res_src = 2'b01; e.reg_write = 1'b1; end
      5:  begin e.mem_req = 1'b1; e.mem_we = 1'b1; e.adr_src = 1'b1; end
      6:  begin e.src_a = 2'b10; e.alu_op = 2'b10; end
      7:  begin e.src_a = 2'b10; e.src_b = 2'b01; e.alu_op = 2'b10; end
      8:  e.reg_write = 1'b1;
      9:  begin e.src_a = 2'b10; e.alu_op = 2'b01; e.branch = 1'b1; end
      10: begin e.src_a = 2'b01; e.src_b = 2'b10; e.pc_write = 1'b1; end
      12: begin e.src_a = (op == OP_LUI) ? 2'b11 : 2'b01; e.src_b = 2'b01; end
      default: ;
    endcase
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m[0] <= reset_model();
      m[1] <= reset_model();
    end else begin
      m[0] <= next_model(m[0], TO_A, EU_A, opcode, mem_ready);
      m[1] <= next_model(m[1], TO_B, EU_B, opcode, mem_ready);
    end
  end

  always @(negedge clk) begin
    if (!done) begin
      check("cycle_a", obs_a, expect_out(m[0], opcode, mem_ready));
      check("cycle_b", obs_b, expect_out(m[1], opcode, mem_ready));
    end
  end

  task automatic drive(input logic [6:0] op, input logic rdy);
    opcode    = op;
    mem_ready = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [6:0] op, input logic rdy, input int exp_state);
    drive(op, rdy);
    check("state_seq", a_state_dbg, exp_state);
    tick();
  endtask

  initial begin : stim
    logic [6:0] op;
    rst_n     = 1'b0;
    opcode    = OP_R;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state_a", a_state_dbg, 14);
    check("reset_state_b", b_state_dbg, 14);
    check("reset_ctrl_a", ctrl_bits(obs_a), 0);
    check("reset_trap_a", {a_trap, a_trap_cause}, 0);
    rst_n = 1'b1;

    // ADD, zero wait states: 14, 0, 1, 6, 8, 0
    cyc(OP_R, 1'b1, 14);
    drive(OP_R, 1'b1);
    check("fetch_irw_pcw", {a_ir_write, a_pc_write}, 2'b11);
    check("state_seq", a_state_dbg, 0);
    tick();
    cyc(OP_R, 1'b1, 1);
    cyc(OP_R, 1'b1, 6);
    drive(OP_R, 1'b1);
    check("aluwb_reg_write", a_reg_write, 1);
    check("state_seq", a_state_dbg, 8);
    tick();

    // lw with three MEMREAD stall cycles; ready during MEMADR is ignored
    cyc(OP_LOAD, 1'b1, 0);
    cyc(OP_LOAD, 1'b1, 1);
    cyc(OP_LOAD, 1'b1, 2);
    for (int i = 0; i < 3; i++) begin
      drive(OP_LOAD, 1'b0);
      check("memread_stall_state", a_state_dbg, 3);
      check("memread_stall_req", {a_mem_req, a_adr_src}, 2'b11);
      tick();
    end
    cyc(OP_LOAD, 1'b1, 3);
    drive(OP_LOAD, 1'b1);
    check("memwb_state", a_state_dbg, 4);
    check("memwb_res_wr", {a_result_src, a_reg_write}, 3'b011);
    tick();

    // sw, zero wait states
    cyc(OP_STORE, 1'b1, 0);
    cyc(OP_STORE, 1'b1, 1);
    cyc(OP_STORE, 1'b1, 2);
    cyc(OP_STORE, 1'b1, 5);

    // beq
    cyc(OP_BR, 1'b1, 0);
    cyc(OP_BR, 1'b1, 1);
    drive(OP_BR, 1'b1);
    check("branch_state", a_state_dbg, 9);
    check("branch_aluop", {a_branch, a_alu_op}, 3'b101);
    check("branch_imm_src", a_imm_src, 3'b010);
    tick();

    // JAL: 0, 1, 10, 8
    cyc(OP_JAL, 1'b1, 0);
    cyc(OP_JAL, 1'b1, 1);
    drive(OP_JAL, 1'b1);
    check("jal_state", a_state_dbg, 10);
    check("jal_pc_write", a_pc_write, 1);
    tick();
    cyc(OP_JAL, 1'b1, 8);

    // I-type
    cyc(OP_I, 1'b1, 0);
    cyc(OP_I, 1'b1, 1);
    cyc(OP_I, 1'b1, 7);
    cyc(OP_I, 1'b1, 8);

    // FETCH stalls right up to the limit, ready arrives when the count sits at 4
    for (int i = 0; i < 4; i++) cyc(OP_R, 1'b0, 0);
    cyc(OP_R, 1'b1, 0);
    cyc(OP_R, 1'b1, 1);
    cyc(OP_R, 1'b1, 6);
    cyc(OP_R, 1'b1, 8);

    // sw stalled in MEMWRITE, reset pulled mid-cycle
    cyc(OP_STORE, 1'b1, 0);
    cyc(OP_STORE, 1'b1, 1);
    cyc(OP_STORE, 1'b1, 2);
    cyc(OP_STORE, 1'b0, 5);
    drive(OP_STORE, 1'b0);
    check("memwrite_we", a_mem_we, 1);
    rst_n = 1'b0;
    #1;
    check("abort_we_a", a_mem_we, 0);
    check("abort_state_a", a_state_dbg, 14);
    check("abort_state_b", b_state_dbg, 14);
    tick();
    tick();
    rst_n = 1'b1;
    cyc(OP_R, 1'b1, 14);
    cyc(OP_R, 1'b1, 0);
    cyc(OP_R, 1'b1, 1);
    cyc(OP_R, 1'b1, 6);
    cyc(OP_R, 1'b1, 8);

    // FETCH stuck: instance a traps with cause 10, instance b (timeout off) waits
    for (int i = 0; i < 5; i++) cyc(OP_R, 1'b0, 0);
    drive(OP_R, 1'b0);
    check("timeout_state_a", a_state_dbg, 15);
    check("timeout_trap_a", {a_trap, a_trap_cause}, 3'b110);
    check("timeout_off_b", b_state_dbg, 0);
    tick();
    for (int i = 0; i < 3; i++) cyc(OP_R, 1'b1, 15);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // LUI: instance a goes through UPPER, instance b traps as illegal
    cyc(OP_LUI, 1'b1, 14);
    cyc(OP_LUI, 1'b1, 0);
    cyc(OP_LUI, 1'b1, 1);
    drive(OP_LUI, 1'b1);
    check("upper_state_a", a_state_dbg, 12);
    check("upper_src_a", a_alu_src_a, 2'b11);
    check("illegal_state_b", b_state_dbg, 15);
    check("illegal_cause_b", {b_trap, b_trap_cause}, 3'b101);
    tick();
    cyc(OP_LUI, 1'b1, 8);
    for (int i = 0; i < 20; i++) begin
      op = (((i / 4) % 2) == 0) ? OP_AUIPC : OP_LUI;
      drive(op, 1'b1);
      check("upper_seq_a", a_state_dbg, upper_seq[i % 4]);
      check("trap_held_ctrl_b", ctrl_bits(obs_b), 0);
      check("trap_held_b", {b_state_dbg, b_trap, b_trap_cause}, 7'b1111_101);
      tick();
    end

    // Unsupported opcode on instance a
    cyc(OP_SYS, 1'b1, 0);
    cyc(OP_SYS, 1'b1, 1);
    drive(OP_SYS, 1'b1);
    check("illegal_state_a", a_state_dbg, 15);
    check("illegal_cause_a", {a_trap, a_trap_cause}, 3'b101);
    tick();
    tick();

    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_main_controller.md
# multicycle_main_controller

Multi-cycle control FSM for the RV32I core, replacing the single-cycle opcode decoder. It sequences each instruction over several states and drives the shared-ALU, single-memory datapath. Memory accesses use a variable-latency ready handshake, with a configurable timeout. Illegal opcodes and memory timeouts enter a sticky trap state.

## Interface
Parameters:
- MEM_TIMEOUT, 16, maximum number of consecutive stall cycles per memory request; 0 disables the timeout.
- ENABLE_U, 1, 1 = LUI (0110111) and AUIPC (0010111) are legal; 0 = both decode as illegal.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  7  instr[6:0] from the instruction register; stable from DECODE until the next FETCH completes.
- mem_ready  in  1  memory has completed the current request this cycle.
- mem_req  out  1  memory request valid.
- mem_we  out  1  write strobe, qualified by mem_req.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load instruction register and OldPC.
- pc_write  out  1  unconditional PC load.
- branch  out  1  the datapath loads PC when branch & zero.
- reg_write  out  1  register file write enable.
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rs1, 11 = zero.
- alu_src_b  out  2  00 = rs2, 01 = ImmExt, 10 = constant 4.
- alu_op  out  2  00 = add, 01 = subtract/compare, 10 = decode funct fields.
- result_src  out  2  00 = ALUOut, 01 = memory data, 10 = live ALU result.
- imm_src  out  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U; combinational from opcode in every state.
- trap  out  1  sticky fault flag.
- trap_cause  out  2  01 = illegal opcode, 10 = memory timeout; 00 when no trap.
- state_dbg  out  4  current state encoding.

## Operation
State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, UPPER=12, IDLE=14, TRAP=15.

Default value of every output in every state is 0. Each state drives only the outputs listed below.
- IDLE: all outputs 0. Next state is always FETCH.
- FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, result_src=10. ir_write and pc_write are 1 only in the cycle where mem_ready=1; the FSM advances to DECODE in that same cycle.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (precomputes the branch/JAL target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - LUI/AUIPC with ENABLE_U=1 -> UPPER
  - anything else -> TRAP with cause 01
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next state is MEMREAD for load, MEMWRITE for store.
- MEMREAD: mem_req=1, adr_src=1. Advances to MEMWB on mem_ready.
- MEMWB: result_src=01, reg_write=1. Next state is FETCH.
- MEMWRITE: mem_req=1, mem_we=1, adr_src=1. Advances to FETCH on mem_ready.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10. Next state is ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10. Next state is ALUWB.
- ALUWB: result_src=00, reg_write=1. Next state is FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1. Next state is FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1. Next state is ALUWB (writes the link value OldPC+4).
- UPPER: alu_src_a=11 for LUI or 01 for AUIPC, alu_src_b=01, alu_op=00. Next state is ALUWB.
- TRAP: all control outputs 0, trap=1, trap_cause held. TRAP exits only on reset.

## Timing
- Reset (async assert, sync release): state=IDLE, every output 0, state_dbg=14, timeout counter 0. FETCH is entered on the first clock edge after release.
- Reset asserted mid-instruction aborts immediately. All outputs go to 0 combinationally from the registered IDLE state, with no write strobe glitch.
- Cycle counts with zero wait states (mem_ready high in the first request cycle):
  - R, I, JAL, LUI: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq: 3 cycles
- Each stall cycle in FETCH, MEMREAD or MEMWRITE adds 1 cycle. Outputs are held stable across stall cycles.
- Timeout counter, width clog2(MEM_TIMEOUT+1):
  - Increments on each mem_req & !mem_ready cycle.
  - Clears on mem_ready or on leaving a memory state.
  - When it reaches MEM_TIMEOUT with mem_ready still low, the next state is TRAP with cause 10.
  - If mem_ready=1 in the cycle the count reaches MEM_TIMEOUT, the handshake completes and no trap is raised.
- mem_ready outside memory states is ignored.
- trap and trap_cause are registered and asserted the cycle TRAP is entered.

## Test plan
- Reset release, then ADD (0110011) with mem_ready tied 1 -> state_dbg sequence 14, 0, 1, 6, 8, 0; reg_write=1 only in state 8; ir_write and pc_write pulse once in state 0.
- lw (0000011) with MEMREAD ready delayed 3 cycles -> sequence 0, 1, 2, 3, 3, 3, 3, 4, 0; mem_req and adr_src=1 held for all 4 MEMREAD cycles; result_src=01 and reg_write=1 in state 4.
- beq (1100011) -> 0, 1, 9, 0 with branch=1, alu_op=01 only in state 9. JAL (1101111) -> 0, 1, 10, 8 with pc_write=1 in state 10.
- Opcode 0110111 with ENABLE_U=0 -> TRAP after DECODE, trap_cause=01, all outputs held 0 for 20 cycles. With ENABLE_U=1 -> state 12 with alu_src_a=11.
- MEM_TIMEOUT=4, mem_ready stuck low in FETCH -> TRAP after 4 stall cycles, trap_cause=10. Repeat with mem_ready rising on the 4th stall cycle -> no trap, DECODE follows.
- sw in MEMWRITE stall, rst_n pulled low mid-cycle -> mem_we drops immediately, state_dbg=14; after release, normal FETCH.
